// File: rtl/aes_gcm_flow_ctrl_pkg.sv
// Shared types and constants for the AES-GCM flow controller and its bypass delay line.
package aes_gcm_pkg;

   localparam int unsigned DATA_W  = 128;
   localparam int unsigned LATENCY = 15;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} flow_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] text;
      logic [DATA_W-1:0] user;
      logic [DATA_W-1:0] keep;
      logic              last;
   } beat_t;

endpackage

// File: rtl/aes_gcm_flow_ctrl_if.sv
// Stream bundle: upstream handshake, datapath launch/return, downstream AXI-Stream master.
interface aes_gcm_flow_ctrl_if #(
   parameter int unsigned DATA_W = 128
) ();

   logic              s_tvalid;
   logic              s_tlast;
   logic              s_tready;
   logic              pipe_in_vld;
   logic [DATA_W-1:0] pipe_out_text;
   logic [DATA_W-1:0] pipe_out_user;
   logic [DATA_W-1:0] pipe_out_keep;
   logic              pipe_out_last;
   logic              m_tvalid;
   logic              m_tready;
   logic [DATA_W-1:0] m_tdata;
   logic [DATA_W-1:0] m_tuser;
   logic [DATA_W-1:0] m_tkeep;
   logic              m_tlast;

   modport slave (
      input  s_tvalid, s_tlast, pipe_out_text, pipe_out_user, pipe_out_keep, pipe_out_last,
             m_tready,
      output s_tready, pipe_in_vld, m_tvalid, m_tdata, m_tuser, m_tkeep, m_tlast
   );

   modport master (
      output s_tvalid, s_tlast, pipe_out_text, pipe_out_user, pipe_out_keep, pipe_out_last,
             m_tready,
      input  s_tready, pipe_in_vld, m_tvalid, m_tdata, m_tuser, m_tkeep, m_tlast
   );

endinterface

// File: rtl/aes_gcm_out_fifo.sv
// Synchronous FIFO of beat_t collecting datapath output; exposes its occupancy for credit accounting.
module aes_gcm_out_fifo
   import aes_gcm_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr,
   input  beat_t         i_wr_beat,
   input  logic          i_rd,
   output logic          o_valid,
   output beat_t         o_beat,
   output logic [CW-1:0] o_count
);

   beat_t         r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_rd;

   assign o_valid = (r_count != '0);
   assign w_rd    = i_rd & o_valid;
   assign o_count = r_count;
   // Zero the head when empty so downstream data is quiet out of reset.
   assign o_beat  = o_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (i_wr) r_mem[r_wr_ptr] <= i_wr_beat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
         if (i_wr && !w_rd)      r_count <= r_count + CW'(1);
         else if (!i_wr && w_rd) r_count <= r_count - CW'(1);
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(i_wr && !w_rd && r_count == CW'(DEPTH)))
            else $error("aes_gcm_out_fifo: write while full");
      end
   end
`endif

endmodule

// File: rtl/aes_gcm_flow_ctrl.sv
// Credit-based flow control around the non-stallable AES-GCM datapath, with framing and drain.
module aes_gcm_flow_ctrl
   import aes_gcm_pkg::*;
#(
   parameter int unsigned DATA_W     = aes_gcm_pkg::DATA_W,
   parameter int unsigned LATENCY    = aes_gcm_pkg::LATENCY,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_gcm_flow_ctrl_if.slave   bus,
   input  logic                 i_flush,
   output logic                 o_flush_done,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_pkt_cnt
);

   localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < LATENCY + 1) begin : g_depth_chk
      $error("FIFO_DEPTH must be at least LATENCY+1");
   end
   if (DATA_W != aes_gcm_pkg::DATA_W) begin : g_width_chk
      $error("DATA_W must match aes_gcm_pkg::DATA_W");
   end

   flow_state_t       r_state;
   logic [LATENCY-1:0] r_vld_sr;
   logic [CRED_W-1:0] r_inflight;
   logic              r_flush_done;
   logic [CNT_W-1:0]  r_pkt_cnt;
   logic [CRED_W-1:0] w_fifo_cnt;
   logic [CRED_W:0]   w_credit_sum;
   logic              w_s_tready;
   logic              w_accept;
   logic              w_retire;
   logic              w_fifo_vld;
   beat_t             w_wr_beat;
   beat_t             w_rd_beat;

   // Every slot in flight already owns a FIFO entry, so retirement can never overflow it.
   assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_fifo_cnt};
   // rst_n gate keeps s_tready low while reset is held.
   assign w_s_tready   = rst_n & (r_state != DRAIN) & (w_credit_sum < (CRED_W + 1)'(FIFO_DEPTH));
   assign w_accept     = bus.s_tvalid & w_s_tready;
   assign w_retire     = r_vld_sr[LATENCY-1];

   assign w_wr_beat.text = bus.pipe_out_text;
   assign w_wr_beat.user = bus.pipe_out_user;
   assign w_wr_beat.keep = bus.pipe_out_keep;
   assign w_wr_beat.last = bus.pipe_out_last;

   aes_gcm_out_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr      (w_retire),
      .i_wr_beat (w_wr_beat),
      .i_rd      (bus.m_tready),
      .o_valid   (w_fifo_vld),
      .o_beat    (w_rd_beat),
      .o_count   (w_fifo_cnt)
   );

   assign bus.s_tready    = w_s_tready;
   assign bus.pipe_in_vld = w_accept;
   assign bus.m_tvalid    = w_fifo_vld;
   assign bus.m_tdata     = w_rd_beat.text;
   assign bus.m_tuser     = w_rd_beat.user;
   assign bus.m_tkeep     = w_rd_beat.keep;
   assign bus.m_tlast     = w_rd_beat.last;
   assign o_flush_done    = r_flush_done;
   assign o_busy          = (r_inflight != '0) | (w_fifo_cnt != '0);
   assign o_pkt_cnt       = r_pkt_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_sr   <= '0;
         r_inflight <= '0;
         r_pkt_cnt  <= '0;
      end else begin
         r_vld_sr <= (r_vld_sr << 1) | LATENCY'(w_accept);
         if (w_accept && !w_retire)      r_inflight <= r_inflight + CRED_W'(1);
         else if (!w_accept && w_retire) r_inflight <= r_inflight - CRED_W'(1);
         if (w_fifo_vld && bus.m_tready && w_rd_beat.last) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         if (i_flush) begin
            r_state <= DRAIN;
         end else begin
            unique case (r_state)
               IDLE:    if (w_accept && !bus.s_tlast) r_state <= STREAM;
               STREAM:  if (w_accept && bus.s_tlast)  r_state <= IDLE;
               DRAIN: begin
                  if (r_inflight == '0 && w_fifo_cnt == '0) begin
                     r_state      <= IDLE;
                     r_flush_done <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
